accel_spi_responder: RTL and testbench
======================================

ACCEL_SPI_RESPONDER -- requirements
Module: accel_spi_responder

Interface
REQ-001 Parameter DEVID, default 8'hE5, value returned at register 0x00.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on sclk, cs_n and sdi.
REQ-003 clk  input  1  system clock, 50 MHz; single clock domain.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 sclk  input  1  SPI clock from master, idle high (mode 3).
REQ-006 cs_n  input  1  SPI chip select, active-low.
REQ-007 sdi  input  1  master-to-responder serial data.
REQ-008 sdo  output  1  responder-to-master serial data.
REQ-009 sdo_oe  output  1  high while sdo is driven; board logic tri-states sdo when low.
REQ-010 sample_x, sample_y, sample_z  input  16 each  live axis values, two's complement.
REQ-011 bw_rate  output  8  contents of register 0x2C.
REQ-012 data_format  output  8  contents of register 0x31.
REQ-013 wr_strobe  output  1  one-clk pulse on every accepted register write.
REQ-014 wr_addr  output  6 / wr_data  output  8  address and data of the accepted write, valid with wr_strobe.

Function
REQ-015 sclk, cs_n, sdi SHALL pass through SYNC_STAGES flops; edges are detected on synchronized sclk; sclk half-period SHALL be at least 4 clk periods.
REQ-016 sclk edges while synchronized cs_n is high SHALL be ignored.
REQ-017 FSM states: IDLE, CMD, DATA; cs_n falling -> CMD with 3-bit bit counter cleared; cs_n rising from any state -> IDLE within 1 clk, partial byte discarded, no write.
REQ-018 On cs_n falling, sample_x/y/z SHALL be snapshotted; all data-register reads in that transaction return the snapshot.
REQ-019 sdi SHALL be shifted in MSB-first on each synchronized sclk rising edge; bit counter increments and wraps 7 -> 0.
REQ-020 Command byte: bit7 = R/W (1 read), bit6 = MB (multi-byte), bits5:0 = start address; latched on 8th rising edge, FSM -> DATA.
REQ-021 Read: at command latch, tx shift register SHALL load register[addr]; on each subsequent sclk falling edge sdo <= tx MSB and tx shifts left, so MSB is valid before the first data rising edge.
REQ-022 Write: on each 8th data rising edge, byte written to register[addr] if writable; wr_strobe pulses 1 clk later with wr_addr/wr_data.
REQ-023 After each completed data byte: MB=1 -> addr increments, 0x3F wraps to 0x00, tx reloads for reads; MB=0 -> addr unchanged, same register repeated.
REQ-024 Register map: 0x00 DEVID (RO); 0x2C bw_rate (RW, reset 8'h0A); 0x2D power_ctl (RW, reset 8'h00, internal); 0x31 data_format (RW, reset 8'h00); 0x32/0x33 X low/high; 0x34/0x35 Y low/high; 0x36/0x37 Z low/high (RO, snapshot).
REQ-025 Unmapped reads SHALL return 8'h00; writes to RO or unmapped addresses SHALL be ignored with no wr_strobe.
REQ-026 sdo_oe SHALL be high only in DATA state of a read transaction with cs_n low; sdo SHALL be 0 otherwise.
REQ-027 Register write and cs_n rising in the same clk: the write completes only if the 8th rising edge was already detected.

Reset
REQ-028 rst_n low SHALL asynchronously force FSM IDLE, counters 0, sdo 0, sdo_oe 0, wr_strobe 0, wr_addr 0, wr_data 0, registers to REQ-024 reset values, snapshot 0.
REQ-029 Reset mid-transaction SHALL abort it; the responder re-arms only on the next cs_n falling edge after rst_n deasserts.

Structure
REQ-030 Shared package holds register address constants, reset values and FSM state encoding.
REQ-031 One sub-module, spi_sync, implements the synchronizer plus rise/fall edge detect, instantiated for sclk and cs_n (sdi uses the synchronizer only).

Verification
REQ-032 Read 0x00 (cmd 8'h80), 2 MHz sclk -> sdo shifts 8'hE5, sdo_oe high for data byte only.
REQ-033 sample_x=16'h1234, y=16'hFFF0, z=16'h0100; multi-byte read from 0x32 (cmd 8'hF2), 6 bytes -> 34 12 F0 FF 00 01; samples changed mid-transfer do not alter result.
REQ-034 Write 8'h0F to 0x2C (cmd 8'h2C) -> bw_rate=8'h0F, one wr_strobe with wr_addr 6'h2C, wr_data 8'h0F.
REQ-035 Write 8'h55 to 0x00 and to 0x10 -> no wr_strobe; reads return E5 and 00.
REQ-036 Multi-byte read from 0x3F, 2 bytes -> 00 then E5 (wrap); cs_n raised after 5 data bits of a write -> no register change.
REQ-037 rst_n pulsed low mid-read -> sdo_oe 0 immediately, bw_rate 8'h0A, next full transaction correct.

Source files
------------

// File: rtl/accel_spi_responder_pkg.sv
// Shared definitions for the accelerometer-style SPI responder:
// register addresses, reset values and FSM state encoding.
`timescale 1ns/1ps
package accel_spi_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;
    localparam logic [5:0] ADDR_DATAX1      = 6'h33;
    localparam logic [5:0] ADDR_DATAY0      = 6'h34;
    localparam logic [5:0] ADDR_DATAY1      = 6'h35;
    localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
    localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

    localparam logic [7:0] RST_BW_RATE     = 8'h0A;
    localparam logic [7:0] RST_POWER_CTL   = 8'h00;
    localparam logic [7:0] RST_DATA_FORMAT = 8'h00;

    function automatic logic is_writable(input logic [5:0] addr);
        return (addr == ADDR_BW_RATE) || (addr == ADDR_POWER_CTL) ||
               (addr == ADDR_DATA_FORMAT);
    endfunction

endpackage

// File: rtl/accel_spi_responder_spi_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
`timescale 1ns/1ps
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d[0] = d_in;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/accel_spi_responder.sv
// Mode-3 SPI register responder with a small accelerometer-style register map.
//   state   | meaning
//   IDLE    | cs_n high, waiting for a cs_n falling edge
//   CMD     | shifting in the command byte (R/W, MB, address)
//   DATA    | moving data bytes; reads drive sdo, writes update registers
`timescale 1ns/1ps
module accel_spi_responder
    import accel_spi_responder_pkg::*;
#(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        sdi,
    output logic        sdo,
    output logic        sdo_oe,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    output logic [7:0]  bw_rate,
    output logic [7:0]  data_format,
    output logic        wr_strobe,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data
);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
        .clk  (clk),
        .rst_n(rst_n),
        .d_in (sclk),
        .q    (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // Resetting to 0 means a cs_n held low through reset never looks like a
    // falling edge, so the responder waits for a fresh transaction.
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
        .clk  (clk),
        .rst_n(rst_n),
        .d_in (cs_n),
        .q    (cs_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic                   sdi_s;

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  rx_q, rx_d;
    logic [7:0]  tx_q, tx_d;
    logic        rw_q, rw_d;
    logic        mb_q, mb_d;
    logic [5:0]  addr_q, addr_d;
    logic        sdo_q, sdo_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [5:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  bw_rate_q, bw_rate_d;
    logic [7:0]  power_ctl_q, power_ctl_d;
    logic [7:0]  data_format_q, data_format_d;
    logic [15:0] snap_x_q, snap_x_d;
    logic [15:0] snap_y_q, snap_y_d;
    logic [15:0] snap_z_q, snap_z_d;

    logic        sck_rise, sck_fall, byte_done;
    logic [7:0]  rx_shift;
    logic [5:0]  addr_next, rd_addr;
    logic [7:0]  rd_data;

    always_comb begin
        sdi_sync_d[0] = sdi;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sdi_sync_d[i] = sdi_sync_q[i-1];
        end
    end
    assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

    assign sck_rise  = sclk_rise & ~cs_s;
    assign sck_fall  = sclk_fall & ~cs_s;
    assign byte_done = (bit_cnt_q == 3'd7);
    assign rx_shift  = {rx_q, sdi_s};
    assign addr_next = mb_q ? addr_q + 6'd1 : addr_q;
    // The tx load address is the fresh command address or the next data address.
    assign rd_addr   = (state_q == ST_CMD) ? rx_shift[5:0] : addr_next;

    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            ADDR_DEVID:       rd_data = DEVID;
            ADDR_BW_RATE:     rd_data = bw_rate_q;
            ADDR_POWER_CTL:   rd_data = power_ctl_q;
            ADDR_DATA_FORMAT: rd_data = data_format_q;
            ADDR_DATAX0:      rd_data = snap_x_q[7:0];
            ADDR_DATAX1:      rd_data = snap_x_q[15:8];
            ADDR_DATAY0:      rd_data = snap_y_q[7:0];
            ADDR_DATAY1:      rd_data = snap_y_q[15:8];
            ADDR_DATAZ0:      rd_data = snap_z_q[7:0];
            ADDR_DATAZ1:      rd_data = snap_z_q[15:8];
            default:          rd_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_d          = rx_q;
        tx_d          = tx_q;
        rw_d          = rw_q;
        mb_d          = mb_q;
        addr_d        = addr_q;
        sdo_d         = sdo_q;
        wr_strobe_d   = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        bw_rate_d     = bw_rate_q;
        power_ctl_d   = power_ctl_q;
        data_format_d = data_format_q;
        snap_x_d      = snap_x_q;
        snap_y_d      = snap_y_q;
        snap_z_d      = snap_z_q;

        if (cs_rise) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            sdo_d     = 1'b0;
        end else if (cs_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = 3'd0;
            rx_d      = 7'd0;
            tx_d      = 8'd0;
            sdo_d     = 1'b0;
            snap_x_d  = sample_x;
            snap_y_d  = sample_y;
            snap_z_d  = sample_z;
        end else begin
            case (state_q)
                ST_CMD: begin
                    if (sck_rise) begin
                        rx_d      = rx_shift[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (byte_done) begin
                            rw_d    = rx_shift[7];
                            mb_d    = rx_shift[6];
                            addr_d  = rx_shift[5:0];
                            tx_d    = rd_data;
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (sck_fall && rw_q) begin
                        sdo_d = tx_q[7];
                        tx_d  = {tx_q[6:0], 1'b0};
                    end
                    if (sck_rise) begin
                        rx_d      = rx_shift[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (byte_done) begin
                            if (!rw_q && is_writable(addr_q)) begin
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = addr_q;
                                wr_data_d   = rx_shift;
                                case (addr_q)
                                    ADDR_BW_RATE:     bw_rate_d     = rx_shift;
                                    ADDR_POWER_CTL:   power_ctl_d   = rx_shift;
                                    ADDR_DATA_FORMAT: data_format_d = rx_shift;
                                    default:          ;
                                endcase
                            end
                            addr_d = addr_next;
                            if (rw_q) begin
                                tx_d = rd_data;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdi_sync_q    <= '0;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            rx_q          <= 7'd0;
            tx_q          <= 8'd0;
            rw_q          <= 1'b0;
            mb_q          <= 1'b0;
            addr_q        <= 6'd0;
            sdo_q         <= 1'b0;
            wr_strobe_q   <= 1'b0;
            wr_addr_q     <= 6'd0;
            wr_data_q     <= 8'd0;
            bw_rate_q     <= RST_BW_RATE;
            power_ctl_q   <= RST_POWER_CTL;
            data_format_q <= RST_DATA_FORMAT;
            snap_x_q      <= 16'd0;
            snap_y_q      <= 16'd0;
            snap_z_q      <= 16'd0;
        end else begin
            sdi_sync_q    <= sdi_sync_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_q          <= rx_d;
            tx_q          <= tx_d;
            rw_q          <= rw_d;
            mb_q          <= mb_d;
            addr_q        <= addr_d;
            sdo_q         <= sdo_d;
            wr_strobe_q   <= wr_strobe_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            bw_rate_q     <= bw_rate_d;
            power_ctl_q   <= power_ctl_d;
            data_format_q <= data_format_d;
            snap_x_q      <= snap_x_d;
            snap_y_q      <= snap_y_d;
            snap_z_q      <= snap_z_d;
        end
    end

    // Mode 3 master: sclk must be idling high when a transaction opens.
    a_mode3_idle: assert property (@(posedge clk) disable iff (!rst_n) cs_fall |-> sclk_s);

    assign sdo_oe      = (state_q == ST_DATA) && rw_q && !cs_s;
    assign sdo         = sdo_oe & sdo_q;
    assign bw_rate     = bw_rate_q;
    assign data_format = data_format_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;

endmodule

// File: tb/tb_accel_spi_responder.sv
// Scoreboard bench: directed SPI transactions push expected read bytes and
// write strobes; independent monitors pop and compare as the DUT produces them.
`timescale 1ns/1ps
module tb_accel_spi_responder;

    localparam time HALF = 250ns;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b1;
    logic        cs_n = 1'b1;
    logic        sdi = 1'b0;
    logic        sdo, sdo_oe;
    logic [15:0] sample_x = 16'h0000;
    logic [15:0] sample_y = 16'h0000;
    logic [15:0] sample_z = 16'h0000;
    logic [7:0]  bw_rate, data_format;
    logic        wr_strobe;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0]  rd_exp_q[$];
    logic [13:0] wr_exp_q[$];

    initial begin
        #3;
        forever #10 clk = ~clk;
    end

    accel_spi_responder #(.DEVID(8'hE5), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .sdi        (sdi),
        .sdo        (sdo),
        .sdo_oe     (sdo_oe),
        .sample_x   (sample_x),
        .sample_y   (sample_y),
        .sample_z   (sample_z),
        .bw_rate    (bw_rate),
        .data_format(data_format),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Read monitor: the master samples sdo on sclk rising edges while driven.
    initial begin : rd_mon
        int         nb;
        logic [7:0] sh;
        nb = 0;
        sh = 8'h00;
        forever begin
            @(posedge sclk or posedge cs_n);
            if (cs_n) begin
                nb = 0;
            end else if (sdo_oe === 1'b1) begin
                sh = {sh[6:0], sdo};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (rd_exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL rd_unexpected: got %0h expected none", sh);
                    end else begin
                        check("rd_byte", {24'd0, sh}, {24'd0, rd_exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin : wr_mon
        forever begin
            @(negedge clk);
            if (wr_strobe === 1'b1) begin
                if (wr_exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL wr_unexpected: got addr %0h data %0h expected none", wr_addr, wr_data);
                end else begin
                    check("wr_strobe", {18'd0, wr_addr, wr_data}, {18'd0, wr_exp_q.pop_front()});
                end
            end
        end
    end

    task automatic cs_low();
        cs_n = 1'b0;
        #(HALF);
    endtask

    task automatic cs_high();
        #(HALF);
        cs_n = 1'b1;
        #(4*HALF);
    endtask

    task automatic send_bits(input logic [7:0] b, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            sclk = 1'b0;
            sdi  = b[i];
            #(HALF);
            sclk = 1'b1;
            #(HALF);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 7, 0);
    endtask

    task automatic read_xfer(input logic [7:0] cmd, input int nbytes);
        cs_low();
        send_byte(cmd);
        for (int k = 0; k < nbytes; k++) send_byte(8'h00);
        cs_high();
    endtask

    task automatic write_xfer(input logic [7:0] cmd, input logic [7:0] data);
        cs_low();
        send_byte(cmd);
        send_byte(data);
        cs_high();
    endtask

    initial begin
        #100;
        check("rst_sdo_oe", {31'd0, sdo_oe}, 32'd0);
        check("rst_sdo", {31'd0, sdo}, 32'd0);
        check("rst_bw_rate", {24'd0, bw_rate}, 32'h0A);
        check("rst_data_format", {24'd0, data_format}, 32'h00);
        check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
        check("rst_wr_addr", {26'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {24'd0, wr_data}, 32'd0);
        rst_n = 1'b1;
        #200;

        // Read DEVID; sdo_oe only during the data byte
        rd_exp_q.push_back(8'hE5);
        cs_low();
        send_bits(8'h80, 7, 4);
        check("oe_in_cmd", {31'd0, sdo_oe}, 32'd0);
        send_bits(8'h80, 3, 0);
        check("oe_in_data", {31'd0, sdo_oe}, 32'd1);
        send_byte(8'h00);
        cs_high();
        check("oe_after_cs", {31'd0, sdo_oe}, 32'd0);

        // Multi-byte axis read from snapshot; live samples change mid-transfer
        sample_x = 16'h1234;
        sample_y = 16'hFFF0;
        sample_z = 16'h0100;
        rd_exp_q.push_back(8'h34);
        rd_exp_q.push_back(8'h12);
        rd_exp_q.push_back(8'hF0);
        rd_exp_q.push_back(8'hFF);
        rd_exp_q.push_back(8'h00);
        rd_exp_q.push_back(8'h01);
        cs_low();
        send_byte(8'hF2);
        send_byte(8'h00);
        send_byte(8'h00);
        sample_x = 16'h5555;
        sample_y = 16'h5555;
        sample_z = 16'h5555;
        for (int k = 0; k < 4; k++) send_byte(8'h00);
        cs_high();

        // Write bw_rate
        wr_exp_q.push_back({6'h2C, 8'h0F});
        write_xfer(8'h2C, 8'h0F);
        check("bw_after_write", {24'd0, bw_rate}, 32'h0F);

        // Writes to read-only and unmapped addresses are dropped
        write_xfer(8'h00, 8'h55);
        write_xfer(8'h10, 8'h55);
        check("bw_after_ro_write", {24'd0, bw_rate}, 32'h0F);
        rd_exp_q.push_back(8'hE5);
        read_xfer(8'h80, 1);
        rd_exp_q.push_back(8'h00);
        read_xfer(8'h90, 1);

        // Address wrap 0x3F -> 0x00
        rd_exp_q.push_back(8'h00);
        rd_exp_q.push_back(8'hE5);
        read_xfer(8'hFF, 2);

        // Partial write byte aborted by cs_n
        cs_low();
        send_byte(8'h2C);
        send_bits(8'hA5, 7, 3);
        cs_high();
        check("bw_after_abort", {24'd0, bw_rate}, 32'h0F);

        // data_format write, then MB=0 repeated read
        wr_exp_q.push_back({6'h31, 8'h0B});
        write_xfer(8'h31, 8'h0B);
        check("data_format_write", {24'd0, data_format}, 32'h0B);
        rd_exp_q.push_back(8'h0B);
        rd_exp_q.push_back(8'h0B);
        read_xfer(8'hB1, 2);

        // Multi-byte write into bw_rate and power_ctl, read back power_ctl
        wr_exp_q.push_back({6'h2C, 8'h07});
        wr_exp_q.push_back({6'h2D, 8'h01});
        cs_low();
        send_byte(8'h6C);
        send_byte(8'h07);
        send_byte(8'h01);
        cs_high();
        check("bw_after_mb_write", {24'd0, bw_rate}, 32'h07);
        rd_exp_q.push_back(8'h01);
        rd_exp_q.push_back(8'h00);
        read_xfer(8'hED, 2);

        // Reset in the middle of a read
        cs_low();
        send_byte(8'hAC);
        send_bits(8'h00, 7, 5);
        rst_n = 1'b0;
        #1;
        check("oe_in_reset", {31'd0, sdo_oe}, 32'd0);
        check("bw_in_reset", {24'd0, bw_rate}, 32'h0A);
        check("data_format_in_reset", {24'd0, data_format}, 32'h00);
        #50;
        rst_n = 1'b1;
        cs_n  = 1'b1;
        #(4*HALF);
        rd_exp_q.push_back(8'h0A);
        read_xfer(8'hAC, 1);
        rd_exp_q.push_back(8'h55);
        rd_exp_q.push_back(8'h55);
        read_xfer(8'hF2, 2);

        #(4*HALF);
        check("rd_queue_drained", rd_exp_q.size(), 32'd0);
        check("wr_queue_drained", wr_exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
